// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue behind the UART receiver: first-word-fall-through
// read port, fill-level flags, and sticky overrun with a saturating drop count.
module uart_rx_fifo #(
    parameter int DataWidth       = 8,
    parameter int Depth           = 16,
    parameter int AlmostFullLevel = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_tick_i,
    input  logic [DataWidth-1:0]       wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [DataWidth-1:0]       rd_data_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic                       overrun_o,
    input  logic                       overrun_clr_i,
    output logic [7:0]                 drop_count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 overrun;
    logic [7:0]           drop_count;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CntW'(Depth));

    // A full queue still accepts a push when the head leaves on the same edge.
    assign pop  = !empty && rd_ready_i;
    assign push = wr_tick_i && (!full || pop);
    assign drop = wr_tick_i && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop coinciding with a clear restarts the tally at one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun    <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (overrun_clr_i) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (overrun_clr_i) begin
            overrun    <= 1'b0;
            drop_count <= 8'd0;
        end
    end

    assign rd_valid_o    = !empty;
    assign rd_data_o     = empty ? '0 : mem[rd_ptr];
    assign count_o       = count;
    assign empty_o       = empty;
    assign full_o        = full;
    assign almost_full_o = (count >= CntW'(AlmostFullLevel));
    assign overrun_o     = overrun;
    assign drop_count_o  = drop_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-level reference model tracks
// accepted words and status; a negedge monitor checks every handshake.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          wr_tick_i = 1'b0;
    logic [DW-1:0] wr_data_i = '0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic [4:0]    count_o;
    logic          empty_o;
    logic          full_o;
    logic          almost_full_o;
    logic          overrun_o;
    logic          overrun_clr_i = 1'b0;
    logic [7:0]    drop_count_o;

    uart_rx_fifo #(.DataWidth(DW), .Depth(DEPTH), .AlmostFullLevel(AFL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_tick_i(wr_tick_i), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
        .almost_full_o(almost_full_o), .overrun_o(overrun_o),
        .overrun_clr_i(overrun_clr_i), .drop_count_o(drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: accepted words queue plus occupancy/overrun bookkeeping.
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    bit            m_ovr   = 0;
    int            m_drop  = 0;

    always @(posedge clk_i or posedge rst_i) begin
        bit m_pop, m_push;
        if (rst_i) begin
            m_count = 0;
            m_ovr   = 0;
            m_drop  = 0;
            exp_q.delete();
        end else begin
            m_pop  = (m_count > 0) && rd_ready_i;
            m_push = wr_tick_i && ((m_count < DEPTH) || m_pop);
            if (m_push) exp_q.push_back(wr_data_i);
            m_count = m_count + int'(m_push) - int'(m_pop);
            if (wr_tick_i && !m_push) begin
                m_ovr  = 1;
                m_drop = overrun_clr_i ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
            end else if (overrun_clr_i) begin
                m_ovr  = 0;
                m_drop = 0;
            end
        end
    end

    // Monitor: every handshake must deliver the oldest outstanding word.
    always @(negedge clk_i) begin
        if (rd_valid_o && rd_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_data: got 0x%0h, expected no word outstanding at %0t", rd_data_o, $time);
            end else begin
                check("pop_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("count", 32'(count_o), 32'(m_count));
            check("valid", 32'(rd_valid_o), 32'(m_count > 0));
            check("empty", 32'(empty_o), 32'(m_count == 0));
            check("full", 32'(full_o), 32'(m_count == DEPTH));
            check("almost_full", 32'(almost_full_o), 32'(m_count >= AFL));
            check("overrun", 32'(overrun_o), 32'(m_ovr));
            check("drop_count", 32'(drop_count_o), 32'(m_drop));
            if (m_count == 0) check("idle_data", 32'(rd_data_o), 32'h0);
        end
    end

    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rdy, input bit clr);
        wr_tick_i     = wr;
        wr_data_i     = d;
        rd_ready_i    = rdy;
        overrun_clr_i = clr;
        @(posedge clk_i);
        #1;
        wr_tick_i     = 1'b0;
        rd_ready_i    = 1'b0;
        overrun_clr_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget && exp_q.size() > 0; i++) step(0, 8'h00, 1, 0);
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int i = 0; i < DEPTH; i++) step(1, base + DW'(i), 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 32'(rd_valid_o), 32'd0);
        check({tag, "_data"}, 32'(rd_data_o), 32'd0);
        check({tag, "_count"}, 32'(count_o), 32'd0);
        check({tag, "_empty"}, 32'(empty_o), 32'd1);
        check({tag, "_full"}, 32'(full_o), 32'd0);
        check({tag, "_afull"}, 32'(almost_full_o), 32'd0);
        check({tag, "_overrun"}, 32'(overrun_o), 32'd0);
        check({tag, "_drops"}, 32'(drop_count_o), 32'd0);
    endtask

    initial begin
        #2;
        check_reset_values("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Basic order
        step(1, 8'h41, 0, 0);
        step(1, 8'h42, 0, 0);
        step(1, 8'h43, 0, 0);
        check("basic_count", 32'(count_o), 32'd3);
        check("basic_head", 32'(rd_data_o), 32'h41);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
        check("basic_empty", 32'(empty_o), 32'd1);
        check("basic_data0", 32'(rd_data_o), 32'd0);

        // Fill, wrap, almost-full
        for (int i = 0; i < DEPTH; i++) begin
            step(1, DW'(i), 0, 0);
            check("afull_ramp", 32'(almost_full_o), 32'(i + 1 >= AFL));
        end
        check("fill_full", 32'(full_o), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + DW'(i), 0, 0);
        check("wrap_full", 32'(full_o), 32'd1);
        check("wrap_head", 32'(rd_data_o), 32'h04);
        drain(40);

        // Overrun and saturation
        fill(8'h10);
        for (int i = 0; i < 3; i++) step(1, 8'hEE, 0, 0);
        check("ovr_flag", 32'(overrun_o), 32'd1);
        check("ovr_drops", 32'(drop_count_o), 32'd3);
        check("ovr_head", 32'(rd_data_o), 32'h10);
        step(0, 8'h00, 0, 1);
        check("clr_flag", 32'(overrun_o), 32'd0);
        check("clr_drops", 32'(drop_count_o), 32'd0);
        for (int i = 0; i < 300; i++) step(1, 8'hEE, 0, 0);
        check("sat_drops", 32'(drop_count_o), 32'd255);
        step(0, 8'h00, 0, 1);

        // Full with simultaneous push and pop
        step(1, 8'h55, 1, 0);
        check("simul_count", 32'(count_o), 32'd16);
        check("simul_ovr", 32'(overrun_o), 32'd0);
        check("simul_head", 32'(rd_data_o), 32'h11);
        drain(40);

        // Drop and clear in the same cycle
        fill(8'h30);
        step(1, 8'hEE, 0, 0);
        step(1, 8'hEE, 0, 0);
        step(1, 8'hEE, 0, 1);
        check("dropclr_flag", 32'(overrun_o), 32'd1);
        check("dropclr_drops", 32'(drop_count_o), 32'd1);
        step(0, 8'h00, 0, 1);
        drain(40);

        // Reset mid-operation
        step(1, 8'h61, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'h62 + DW'(i), 0, 0);
        check("pre_rst_count", 32'(count_o), 32'd5);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(1, 8'h99, 0, 0);
        check("post_rst_data", 32'(rd_data_o), 32'h99);
        check("post_rst_count", 32'(count_o), 32'd1);
        drain(10);

        // Randomized traffic, alternating producer-heavy and consumer-heavy bias
        for (int i = 0; i < 3000; i++) begin
            int wr_pct;
            wr_pct = ((i / 500) % 2 == 0) ? 70 : 35;
            step($urandom_range(99) < wr_pct, DW'($urandom), $urandom_range(99) < 50,
                 $urandom_range(99) < 3);
        end
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Each one-cycle `rx_done_tick_o` pulse from the receiver, with its `dout_o` byte, is captured into a first-in-first-out queue. The queue is presented to the host or bus side through a first-word-fall-through valid/ready interface. The block provides fill-level status and a sticky overrun flag with a saturating drop counter, so bytes lost at a full queue are detectable.

## Interface
- `DataWidth`, default 8: width of each stored word; matches the receiver's `dout_o`.
- `Depth`, default 16: number of entries; power of two, at least 2.
- `AlmostFullLevel`, default 12: `almost_full_o` asserts when count is at or above this value; range 1..`Depth`.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `wr_tick_i`, input, 1: one-cycle push strobe; connects to the receiver's `rx_done_tick_o`.
- `wr_data_i`, input, `DataWidth`: push data; connects to the receiver's `dout_o`.
- `rd_valid_o`, output, 1: head entry is available.
- `rd_ready_i`, input, 1: consumer accepts the head entry.
- `rd_data_o`, output, `DataWidth`: head entry; forced to 0 when `rd_valid_o` is 0.
- `count_o`, output, `$clog2(Depth)+1`: current number of stored entries, 0..`Depth`.
- `empty_o`, output, 1: count equals 0.
- `full_o`, output, 1: count equals `Depth`.
- `almost_full_o`, output, 1: count is at or above `AlmostFullLevel`.
- `overrun_o`, output, 1: sticky flag; a push was dropped.
- `overrun_clr_i`, input, 1: synchronous clear of `overrun_o` and `drop_count_o`.
- `drop_count_o`, output, 8: dropped pushes since the last clear; saturates at 255.

## Operation
- **Storage:** flop array of `Depth` x `DataWidth`, plus write pointer, read pointer and count register.
  - Pointers are `$clog2(Depth)` bits wide and wrap naturally from `Depth`-1 to 0.
- **Pop:** occurs when `rd_valid_o && rd_ready_i`.
  - The read pointer advances and count decrements.
  - `rd_ready_i` has no effect while `rd_valid_o` is 0.
- **Push:** occurs when `wr_tick_i` is 1 and either (count < `Depth`) or a pop occurs in the same cycle.
  - `wr_data_i` is written at the write pointer, the pointer advances and count increments.
- **Simultaneous push and pop:**
  - Both are performed and count is unchanged.
  - When full, this is allowed: the freed slot is reused in the same cycle.
  - When empty, only the push is performed, because `rd_valid_o` is 0.
- **Dropped push:** `wr_tick_i` while full with no pop in the same cycle.
  - Storage, pointers and count are unchanged.
  - `overrun_o` is set to 1.
  - `drop_count_o` increments, saturating at 255.
- **Overrun clear:** `overrun_clr_i` clears `overrun_o` to 0 and `drop_count_o` to 0.
  - If a drop occurs in the same cycle as a clear, the drop wins: `overrun_o` = 1 and `drop_count_o` = 1.
- **Status outputs:** `rd_valid_o` = !`empty_o`; `rd_data_o` = mem[rd_ptr] gated by `rd_valid_o`. All status outputs derive from registered count.

## Timing
- **Reset values:**
  - `rd_valid_o` = 0, `rd_data_o` = 0, `count_o` = 0.
  - `empty_o` = 1, `full_o` = 0, `almost_full_o` = 0.
  - `overrun_o` = 0, `drop_count_o` = 0.
  - Pointers = 0; memory contents are not reset.
- **Reset mid-operation:** asserting `rst_i` discards all stored entries immediately (asynchronous). The first push after deassertion is written to entry 0.
- **Push-to-valid latency:** a push on edge N makes `rd_valid_o` = 1 and `rd_data_o` = that word after edge N, i.e. visible in cycle N+1.
- **Pop:** takes effect on the clock edge where `rd_valid_o && rd_ready_i`. The next head appears in the following cycle, or `rd_valid_o` falls if the queue becomes empty.
- **Flag and counter updates:** `count_o`, all flags and `drop_count_o` update on the same edge as the push, pop or drop that changes them.
- **Throughput:** one push and one pop per cycle. `wr_tick_i` is never held for more than one cycle by the receiver; if held, each high cycle counts as a separate push.
- **Combinational paths:** no combinational path from `wr_tick_i` or `rd_ready_i` to any output.

## Test plan
- **Basic order:** after reset, push 0x41, 0x42, 0x43 on separate ticks with `rd_ready_i` = 0.
  - Required: `count_o` = 3, `rd_data_o` = 0x41.
  - Then hold `rd_ready_i` = 1: 0x41, 0x42, 0x43 are read on three consecutive cycles, then `empty_o` = 1 and `rd_data_o` = 0.
- **Fill, wrap and almost-full:** push 16 bytes 0x00..0x0F.
  - Required: `almost_full_o` rises when the 12th push lands; `full_o` = 1 at count 16.
  - Pop 4, push 0xA0..0xA3; drain: order is 0x04..0x0F then 0xA0..0xA3, confirming pointer wrap.
- **Overrun:** with the queue full and `rd_ready_i` = 0, issue 3 pushes.
  - Required: `overrun_o` = 1, `drop_count_o` = 3, contents unchanged.
  - Pulse `overrun_clr_i`: both return to 0.
  - Issue 300 dropped pushes: `drop_count_o` saturates at 255.
- **Full with simultaneous push and pop:** with the queue full, `wr_tick_i` = 1 with 0x55 and `rd_ready_i` = 1 in the same cycle.
  - Required: count stays 16, `overrun_o` stays 0, 0x55 is read last on drain.
- **Drop and clear in the same cycle:** with the queue full, assert `overrun_clr_i` in the same cycle as a dropped push.
  - Required: `overrun_o` = 1, `drop_count_o` = 1.
- **Reset mid-operation:** assert `rst_i` asynchronously with 5 entries stored.
  - Required: outputs immediately take their reset values.
  - After release, push 0x99: `rd_data_o` = 0x99 and `count_o` = 1.
